// File: rtl/mem_stage.sv
// MEM stage: issues one data-memory request per load/store, latency 2+N stall cycles (0 for non-memory ops);
// stall_o holds the pipeline until the response, at most one request outstanding, DONE waits for advance_i.
module mem_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        insn_valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_f_i,
  input  logic [31:0] rs2_data_i,
  input  logic        advance_i,
  input  logic        dmem_resp_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        dmem_read_o,
  output logic        dmem_write_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_wmask_o,
  output logic [31:0] dmem_wdata_o,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        read_q, write_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  mask_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        memop, is_store, aligned, latch_en;
  logic [3:0]  mask_d;
  logic [31:0] wdata_d, shifted, load_ext;

  assign memop    = insn_valid_i & (mem_read_i | mem_write_i);
  assign is_store = mem_write_i;

  // Size decode uses funct3[1:0] only, so reserved encodings fall through to word.
  always_comb begin
    aligned = 1'b1;
    mask_d  = 4'b1111;
    wdata_d = rs2_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        aligned = 1'b1;
        mask_d  = 4'b0001 << alu_f_i[1:0];
        wdata_d = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        aligned = ~alu_f_i[0];
        mask_d  = 4'b0011 << alu_f_i[1:0];
        wdata_d = {2{rs2_data_i[15:0]}};
      end
      default: begin
        aligned = (alu_f_i[1:0] == 2'b00);
        mask_d  = 4'b1111;
        wdata_d = rs2_data_i;
      end
    endcase
  end

  assign shifted = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    misaligned_o = 1'b0;
    rdata_o      = 32'd0;
    latch_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          if (aligned) begin
            stall_o  = 1'b1;
            latch_en = 1'b1;
            state_d  = BUSY;
          end else begin
            misaligned_o = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (dmem_resp_i) state_d = DONE;
      end
      DONE: begin
        rdata_o = rdata_q;
        if (advance_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      mask_q   <= 4'd0;
      rdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q   <= {alu_f_i[31:2], 2'b00};
        mask_q   <= is_store ? mask_d : 4'd0;
        wdata_q  <= is_store ? wdata_d : 32'd0;
        funct3_q <= funct3_i;
        off_q    <= alu_f_i[1:0];
        read_q   <= ~is_store;
        write_q  <= is_store;
      end
      // The request drops on the same edge the response is accepted.
      if (state_q == BUSY && dmem_resp_i) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
        rdata_q <= write_q ? 32'd0 : load_ext;
      end
    end
  end

  assign dmem_read_o  = read_q;
  assign dmem_write_o = write_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wmask_o = mask_q;
  assign dmem_wdata_o = wdata_q;

endmodule
